// File: rtl/vga_tile_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_tile_pkg : shared timing defaults, bus map helpers, colour type        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_tile_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_ADDR_W   = 10;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Palette window sits in the upper half of the register space.
  function automatic int pal_base(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

  localparam int DEF_PAL_BASE = pal_base(DEF_ADDR_W);

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// +--------------------------------------------------------------------------+
// | vga_timing : pixel divider, h/v counters, sync/active and frame_tick      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_timing
  import vga_tile_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_en_o,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_tick_o
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;
  logic          frame_tick_q;

  generate
    if (CLK_DIV == 1) begin : g_no_div
      assign pix_en_o = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      logic [DW-1:0] div_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_q + DW'(1);
      end
      // Power-of-two divide: the enable fires on the all-ones count.
      assign pix_en_o = &div_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= pix_en_o && (h_cnt_q == '0) && (v_cnt_q == '0);
      if (pix_en_o) begin
        if (32'(h_cnt_q) == H_TOTAL - 1) begin
          h_cnt_q <= '0;
          v_cnt_q <= (32'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_q <= h_cnt_q + HW'(1);
        end
      end
    end
  end

  assign h_cnt_o      = h_cnt_q;
  assign v_cnt_o      = v_cnt_q;
  assign frame_tick_o = frame_tick_q;
  assign active_o     = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
  assign hsync_o      = (32'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                        (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
  assign vsync_o      = (32'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                        (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);

endmodule

`default_nettype wire

// File: rtl/vga_tile_display.sv
// +--------------------------------------------------------------------------+
// | vga_tile_display : tile/palette VGA renderer with CPU port and blink      |
// | Optional grid lines via `define GRID_LINE_EN.  Rev 1.0                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_tile_display
  import vga_tile_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter bit SYNC_POL     = 1'b0,
  parameter int TILE_SHIFT   = 5,
  parameter int GRID_W       = 20,
  parameter int GRID_H       = 15,
  parameter int STATE_W      = 4,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               over,
  input  logic               state_we,
  input  logic [ADDR_W-1:0]  reg_addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int HW     = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW     = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int NTILES = GRID_W * GRID_H;
  localparam int TIDX_W = (NTILES > 1) ? $clog2(NTILES) : 1;
  localparam int NPAL   = 1 << STATE_W;
  localparam int RGB_W  = 3 * COLOR_W;
  localparam int PAL_LO = pal_base(ADDR_W);
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          pix_en, t_active, t_hs, t_vs;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .reset(reset), .pix_en_o(pix_en), .h_cnt_o(h_cnt), .v_cnt_o(v_cnt),
    .active_o(t_active), .hsync_o(t_hs), .vsync_o(t_vs), .frame_tick_o(frame_tick)
  );

  logic [STATE_W-1:0] state_q [NTILES];
  logic [RGB_W-1:0]   pal_q   [NPAL];
  logic [31:0]        data_out_q, data_out_d;
  logic               tile_hit, pal_hit;
  logic [TIDX_W-1:0]  cpu_tidx;
  logic [STATE_W-1:0] cpu_pidx;
  logic               unused_data_bits;

  assign unused_data_bits = ^data_in[31:RGB_W];

  always_comb begin
    tile_hit   = 32'(reg_addr) < NTILES;
    pal_hit    = (32'(reg_addr) >= PAL_LO) && (32'(reg_addr) < PAL_LO + NPAL);
    cpu_tidx   = reg_addr[TIDX_W-1:0];
    cpu_pidx   = reg_addr[STATE_W-1:0];
    data_out_d = '0;
    if (tile_hit)     data_out_d = 32'(state_q[cpu_tidx]);
    else if (pal_hit) data_out_d = 32'(pal_q[cpu_pidx]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTILES; i++) state_q[i] <= '0;
      for (int i = 0; i < NPAL; i++)   pal_q[i]   <= '0;
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      if (state_we && tile_hit) state_q[cpu_tidx] <= data_in[STATE_W-1:0];
      if (state_we && pal_hit)  pal_q[cpu_pidx]   <= data_in[RGB_W-1:0];
    end
  end

  assign data_out = data_out_q;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (!over) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (frame_tick) begin
      if (32'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  logic [HW-1:0]      s1_tx_q;
  logic [VW-1:0]      s1_ty_q;
  logic               s1_in_grid_q, s1_active_q, s1_hs_q, s1_vs_q;
  logic [HW-1:0]      tx_d;
  logic [VW-1:0]      ty_d;
  logic [TIDX_W-1:0]  pix_tidx;
  logic [STATE_W-1:0] pix_state;
  logic [RGB_W-1:0]   rgb_d, rgb_q;
  logic               hsync_q, vsync_q;
`ifdef GRID_LINE_EN
  logic               s1_line_q;
`endif

  assign tx_d = h_cnt >> TILE_SHIFT;
  assign ty_d = v_cnt >> TILE_SHIFT;

  // Stage 2 reads the array combinationally, so a same-edge CPU write shows next pixel.
  always_comb begin
    pix_tidx  = s1_in_grid_q ? TIDX_W'(32'(s1_ty_q) * GRID_W + 32'(s1_tx_q)) : '0;
    pix_state = s1_in_grid_q ? state_q[pix_tidx] : '0;
    rgb_d     = pal_q[pix_state];
`ifdef GRID_LINE_EN
    if (s1_in_grid_q && s1_line_q) rgb_d = pal_q[NPAL-1];
`endif
    if (blink_q)      rgb_d = ~rgb_d;
    if (!s1_active_q) rgb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_tx_q      <= '0;
      s1_ty_q      <= '0;
      s1_in_grid_q <= 1'b0;
      s1_active_q  <= 1'b0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
`ifdef GRID_LINE_EN
      s1_line_q    <= 1'b0;
`endif
      rgb_q        <= '0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
    end else if (pix_en) begin
      s1_tx_q      <= tx_d;
      s1_ty_q      <= ty_d;
      s1_in_grid_q <= (32'(tx_d) < GRID_W) && (32'(ty_d) < GRID_H);
      s1_active_q  <= t_active;
      s1_hs_q      <= t_hs;
      s1_vs_q      <= t_vs;
`ifdef GRID_LINE_EN
      s1_line_q    <= (h_cnt[TILE_SHIFT-1:0] == '0) || (v_cnt[TILE_SHIFT-1:0] == '0);
`endif
      rgb_q        <= rgb_d;
      hsync_q      <= s1_hs_q ? SYNC_POL : ~SYNC_POL;
      vsync_q      <= s1_vs_q ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign red   = rgb_q[RGB_W-1 -: COLOR_W];
  assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue  = rgb_q[COLOR_W-1:0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_tile_display.sv
// +--------------------------------------------------------------------------+
// | tb_vga_tile_display : directed checks on a reduced 24x16-pixel raster     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_tile_display;

  // Reduced raster: 24 px/line, 16 lines, 2 clk/pixel -> 384 px, 768 clk per frame.
  localparam int FRAME = 384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        over = 1'b0;
  logic        state_we = 1'b0;
  logic [9:0]  reg_addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, frame_tick;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int edge_n = 0;
  int hs_low = 0;

  always #5 clk = ~clk;

  vga_tile_display #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0),
    .TILE_SHIFT(2), .GRID_W(3), .GRID_H(2), .STATE_W(4), .COLOR_W(4),
    .ADDR_W(10), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .over(over), .state_we(state_we),
    .reg_addr(reg_addr), .data_in(data_in), .data_out(data_out),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic wait_edge(input int e);
    if (e < edge_n) check("schedule", edge_n, e);
    while (edge_n < e) step();
  endtask

  // Pixel n is registered by stage 2 on clk edge 2n+4 after reset release.
  task automatic px(input int n);
    wait_edge(2 * n + 4);
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    check(tag, {20'h0, red, green, blue}, {20'h0, exp});
  endtask

  task automatic cpu_wr(input logic [9:0] a, input logic [31:0] d);
    reg_addr = a;
    data_in  = d;
    state_we = 1'b1;
    step();
    state_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_rgb("reset_rgb", 12'h000);
    check("reset_hsync", hsync, 1);
    check("reset_vsync", vsync, 1);
    check("reset_ftick", frame_tick, 0);
    check("reset_dout", data_out, 0);

    reset = 1'b0;
    edge_n = 0;
    step(); check("ftick_e1", frame_tick, 0);
    step(); check("ftick_e2", frame_tick, 1);
    step(); check("ftick_e3", frame_tick, 0);

    cpu_wr(10'd512, 32'h123);
    cpu_wr(10'd515, 32'hF00);
    cpu_wr(10'd517, 32'h0A5);
    cpu_wr(10'd4, 32'h3);
    cpu_wr(10'd2, 32'h5);
    cpu_wr(10'd5, 32'hFFFF_FFFA);
    check("rd_same_clk_old", data_out, 32'h0);
    step(); check("rd_state5", data_out, 32'h0000_000A);
    cpu_wr(10'd528, 32'hFFF);
    step(); check("rd_unmapped_pal", data_out, 32'h0);
    cpu_wr(10'd6, 32'hF);
    step(); check("rd_past_tiles", data_out, 32'h0);
    reg_addr = 10'd400;
    step(); check("rd_addr400", data_out, 32'h0);
    reg_addr = 10'd515;
    step(); check("rd_pal3", data_out, 32'h0000_0F00);
    reg_addr = 10'd0;

    wait_edge(769); check("ftick_f1_pre", frame_tick, 0);
    step();         check("ftick_f1", frame_tick, 1);
    step();         check("ftick_f1_post", frame_tick, 0);

    px(FRAME + 24 + 9); chk_rgb("tile_2_0", 12'h0A5);
    for (int h = 0; h < 24; h++) begin
      px(FRAME + 48 + h);
      if (!hsync) hs_low++;
      if (h == 13) chk_rgb("offgrid_x", 12'h123);
      if (h == 16) chk_rgb("blank_h", 12'h000);
      if (h == 18) check("hsync_on", hsync, 0);
      if (h == 21) check("hsync_off", hsync, 1);
    end
    check("hsync_width", hs_low, 3);
    px(FRAME + 96 + 3);  chk_rgb("tile_0_1", 12'h123);
    px(FRAME + 96 + 4);  chk_rgb("tile_1_1_edge", 12'hF00);
    px(FRAME + 120 + 5); chk_rgb("tile_1_1_mid", 12'hF00);
    px(FRAME + 120 + 8); chk_rgb("tile_2_1", 12'h000);
    px(FRAME + 216 + 5); chk_rgb("offgrid_y", 12'h123);
    px(FRAME + 288 + 5); chk_rgb("blank_v", 12'h000);
    check("vsync_v12", vsync, 1);
    px(FRAME + 312); check("vsync_v13", vsync, 0);
    px(FRAME + 336); check("vsync_v14", vsync, 0);
    px(FRAME + 360); check("vsync_v15", vsync, 1);

    over = 1'b1;
    wait_edge(1537); check("ftick_f2_pre", frame_tick, 0);
    step();          check("ftick_f2", frame_tick, 1);
    px(2 * FRAME + 99);  chk_rgb("blink_f2_norm", 12'h123);
    px(3 * FRAME + 64);  chk_rgb("blink_f3_blank", 12'h000);
    px(3 * FRAME + 99);  chk_rgb("blink_f3_inv", 12'hEDC);
    px(3 * FRAME + 125); chk_rgb("blink_f3_tile", 12'h0FF);
    px(4 * FRAME + 99);  chk_rgb("blink_f4_inv", 12'hEDC);
    over = 1'b0;
    px(5 * FRAME + 99);  chk_rgb("over_drop", 12'h123);
    px(5 * FRAME + 125); chk_rgb("pre_reset_px", 12'hF00);
    reg_addr = 10'd515;
    step(); check("pre_reset_dout", data_out, 32'h0000_0F00);

    reset = 1'b1;
    #1;
    chk_rgb("midreset_rgb", 12'h000);
    check("midreset_hsync", hsync, 1);
    check("midreset_vsync", vsync, 1);
    check("midreset_dout", data_out, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    edge_n = 0;
    step(); check("restart_ftick_e1", frame_tick, 0);
    check("pal_cleared", data_out, 0);
    step(); check("restart_ftick_e2", frame_tick, 1);
    px(17); check("restart_h17", hsync, 1);
    px(18); check("restart_h18", hsync, 0);
    chk_rgb("restart_rgb", 12'h000);
    reg_addr = 10'd4;
    step(); check("state_cleared", data_out, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
